// File: rtl/mc14500_pkg.sv
// Shared constants for the MC14500B output-latch controller.
// State encodings, latch geometry and a mask helper.
package mc14500_pkg;

  localparam int LATCH_AW = 3;
  localparam int LATCH_W  = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_EMPTY  = 3'd4;

  // Bits strictly above idx; idx = 7 yields an empty mask.
  function automatic logic [LATCH_W-1:0] above_mask(
    input logic [LATCH_AW-1:0] idx
  );
    logic [LATCH_W-1:0] m;
    m = 8'hFE << idx;
    return m;
  endfunction

endpackage

// File: rtl/mc14500_lsb_find.sv
// Lowest-set-bit finder over an 8-bit mask.
// Returns the index of the lowest set bit and a valid flag.
module mc14500_lsb_find
  import mc14500_pkg::*;
(
  input  logic [LATCH_W-1:0]  mask_i,
  output logic [LATCH_AW-1:0] idx_o,
  output logic                vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = |mask_i;
    for (int i = LATCH_W - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = LATCH_AW'(i);
    end
  end

endmodule

// File: rtl/mc14500_latch_ctrl.sv
// MC14500B output-latch write sequencer/arbiter with shadow readback.
// MC14500_LATCH_CTRL_RR_EN selects round-robin over fixed r0 priority.
module mc14500_latch_ctrl
  import mc14500_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_req,
  input  logic [LATCH_AW-1:0] r0_addr,
  input  logic                r0_dat,
  output logic                r0_ack,
  input  logic                r1_req,
  input  logic [LATCH_W-1:0]  r1_byte,
  input  logic [LATCH_W-1:0]  r1_mask,
  output logic                r1_ack,
  output logic [LATCH_AW-1:0] l_a,
  output logic                l_dat,
  output logic                l_stb,
  output logic [LATCH_W-1:0]  q_shadow,
  output logic                busy
);

  logic [2:0]          state_q, state_d;
  logic [LATCH_AW-1:0] idx_q, idx_d;
  logic                dat_q, dat_d;
  logic                who_q, who_d;
  logic [LATCH_W-1:0]  byte_q, byte_d;
  logic [LATCH_W-1:0]  mask_q, mask_d;
  logic [LATCH_W-1:0]  shadow_q, shadow_d;

  logic [LATCH_W-1:0]  find_mask;
  logic [LATCH_AW-1:0] find_idx;
  logic                find_vld;
  logic                gnt0, gnt1;

  // IDLE searches the incoming mask; HOLD searches above the current bit.
  assign find_mask = (state_q == S_IDLE) ? r1_mask
                   : (mask_q & above_mask(idx_q));

  mc14500_lsb_find u_find (
    .mask_i (find_mask),
    .idx_o  (find_idx),
    .vld_o  (find_vld)
  );

`ifdef MC14500_LATCH_CTRL_RR_EN
  logic pri_q, pri_d;

  assign gnt1 = r1_req & (~r0_req | pri_q);

  always_comb begin
    pri_d = pri_q;
    if (state_q == S_IDLE && (gnt0 || gnt1)) pri_d = gnt0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pri_q <= 1'b0;
    else      pri_q <= pri_d;
  end
`else
  assign gnt1 = r1_req & ~r0_req;
`endif

  assign gnt0 = r0_req & ~gnt1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dat_d    = dat_q;
    who_d    = who_q;
    byte_d   = byte_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          idx_d   = r0_addr;
          dat_d   = r0_dat;
          who_d   = 1'b0;
          mask_d  = '0;
          state_d = S_SETUP;
        end else if (gnt1) begin
          who_d  = 1'b1;
          byte_d = r1_byte;
          mask_d = r1_mask;
          if (find_vld) begin
            idx_d   = find_idx;
            dat_d   = r1_byte[find_idx];
            state_d = S_SETUP;
          end else begin
            state_d = S_EMPTY;
          end
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: begin
        shadow_d[idx_q] = dat_q;
        state_d         = S_HOLD;
      end
      S_HOLD: begin
        if (find_vld) begin
          idx_d   = find_idx;
          dat_d   = byte_q[find_idx];
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMPTY:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      dat_q    <= 1'b0;
      who_q    <= 1'b0;
      byte_q   <= '0;
      mask_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
      who_q    <= who_d;
      byte_q   <= byte_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
    end
  end

  assign l_a      = idx_q;
  assign l_dat    = dat_q;
  assign l_stb    = (state_q == S_STROBE);
  assign busy     = (state_q != S_IDLE);
  assign q_shadow = shadow_q;
  assign r0_ack   = (state_q == S_HOLD) & ~who_q & ~find_vld;
  assign r1_ack   = ((state_q == S_HOLD) & who_q & ~find_vld)
                  | (state_q == S_EMPTY);

endmodule

// File: tb/tb_mc14500_latch_ctrl.sv
// Directed bench for mc14500_latch_ctrl.
// Cycle 0 is the grant cycle; outputs are sampled on the falling edge.
module tb_mc14500_latch_ctrl;

  logic       clk;
  logic       rst;
  logic       r0_req;
  logic [2:0] r0_addr;
  logic       r0_dat;
  logic       r0_ack;
  logic       r1_req;
  logic [7:0] r1_byte;
  logic [7:0] r1_mask;
  logic       r1_ack;
  logic [2:0] l_a;
  logic       l_dat;
  logic       l_stb;
  logic [7:0] q_shadow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mc14500_latch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .r0_req   (r0_req),
    .r0_addr  (r0_addr),
    .r0_dat   (r0_dat),
    .r0_ack   (r0_ack),
    .r1_req   (r1_req),
    .r1_byte  (r1_byte),
    .r1_mask  (r1_mask),
    .r1_ack   (r1_ack),
    .l_a      (l_a),
    .l_dat    (l_dat),
    .l_stb    (l_stb),
    .q_shadow (q_shadow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Drives one byte load and records strobes, acks and pin stability.
  task automatic run_r1(
    input  logic [7:0]  b,
    input  logic [7:0]  m,
    output int          ack_cyc,
    output int          n_ack,
    output int          n_stb,
    output logic [23:0] a_log,
    output logic [7:0]  d_log,
    output int          unstable
  );
    int         c;
    logic [2:0] pa;
    logic       pd;
    logic       ps;
    @(posedge clk); #1;
    r1_req = 1'b1; r1_byte = b; r1_mask = m;
    ack_cyc = -1; n_ack = 0; n_stb = 0; unstable = 0;
    a_log = '0; d_log = '0;
    pa = l_a; pd = l_dat; ps = 1'b0;
    c = -1;
    while (c < 40 && ack_cyc < 0) begin
      @(negedge clk);
      c++;
      if (ps && (l_a !== pa || l_dat !== pd)) unstable++;
      if (l_stb) begin
        if (l_a !== pa || l_dat !== pd) unstable++;
        if (n_stb < 8) begin
          a_log[3*n_stb +: 3] = l_a;
          d_log[n_stb]        = l_dat;
        end
        n_stb++;
      end
      if (r1_ack) begin
        n_ack++;
        ack_cyc = c;
      end
      pa = l_a; pd = l_dat; ps = l_stb;
    end
    @(posedge clk); #1;
    r1_req = 1'b0;
    @(negedge clk);
    if (r1_ack) n_ack++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    r0_req = 1'b0; r0_addr = '0; r0_dat = 1'b0;
    r1_req = 1'b0; r1_byte = '0; r1_mask = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({l_a, l_dat, l_stb, r0_ack, r1_ack, busy, q_shadow} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0000",
               {l_a, l_dat, l_stb, r0_ack, r1_ack, busy, q_shadow});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy got %b want 0", busy);
    end
  endtask

  task automatic test_r0_write;
    @(posedge clk); #1;
    r0_req = 1'b1; r0_addr = 3'd5; r0_dat = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (l_a !== 3'd5 || l_dat !== 1'b1 || l_stb !== (c == 2)
          || r0_ack !== (c == 3) || busy !== 1'b1) begin
        errors++;
        $display("FAIL r0_cycle%0d: a=%0d d=%b stb=%b ack=%b busy=%b want a=5 d=1 stb=%b ack=%b busy=1",
                 c, l_a, l_dat, l_stb, r0_ack, busy, c == 2, c == 3);
      end
    end
    checks++;
    if (q_shadow !== 8'h20) begin
      errors++;
      $display("FAIL r0_shadow: got %h want 20", q_shadow);
    end
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || l_a !== 3'd5 || l_dat !== 1'b1 || r0_ack !== 1'b0) begin
      errors++;
      $display("FAIL r0_idle: busy=%b a=%0d d=%b ack=%b want 0 5 1 0",
               busy, l_a, l_dat, r0_ack);
    end
  endtask

  task automatic test_byte_full;
    int          ac, na, ns, un;
    logic [23:0] al;
    logic [7:0]  dl;
    run_r1(8'hA5, 8'hFF, ac, na, ns, al, dl, un);
    checks++;
    if (ac !== 24 || na !== 1) begin
      errors++;
      $display("FAIL full_ack: cycle=%0d count=%0d want 24 1", ac, na);
    end
    checks++;
    if (ns !== 8 || al !== 24'hFAC688 || dl !== 8'hA5) begin
      errors++;
      $display("FAIL full_strobes: n=%0d addrs=%h dats=%h want 8 fac688 a5",
               ns, al, dl);
    end
    checks++;
    if (un !== 0) begin
      errors++;
      $display("FAIL full_stable: unstable=%0d want 0", un);
    end
    checks++;
    if (q_shadow !== 8'hA5) begin
      errors++;
      $display("FAIL full_shadow: got %h want a5", q_shadow);
    end
  endtask

  task automatic test_byte_sparse;
    int          ac, na, ns, un;
    logic [23:0] al;
    logic [7:0]  dl;
    run_r1(8'h80, 8'h81, ac, na, ns, al, dl, un);
    checks++;
    if (ac !== 6 || na !== 1) begin
      errors++;
      $display("FAIL sparse_ack: cycle=%0d count=%0d want 6 1", ac, na);
    end
    checks++;
    if (ns !== 2 || al[5:0] !== 6'o70 || dl[1:0] !== 2'b10 || un !== 0) begin
      errors++;
      $display("FAIL sparse_strobes: n=%0d a=%o d=%b un=%0d want 2 70 10 0",
               ns, al[5:0], dl[1:0], un);
    end
    checks++;
    if (q_shadow !== 8'hA4) begin
      errors++;
      $display("FAIL sparse_shadow: got %h want a4", q_shadow);
    end
  endtask

  task automatic test_byte_empty;
    int          ac, na, ns, un;
    logic [23:0] al;
    logic [7:0]  dl;
    run_r1(8'hFF, 8'h00, ac, na, ns, al, dl, un);
    checks++;
    if (ac !== 1 || na !== 1 || ns !== 0) begin
      errors++;
      $display("FAIL empty_ack: cycle=%0d count=%0d strobes=%0d want 1 1 0",
               ac, na, ns);
    end
    checks++;
    if (q_shadow !== 8'hA4) begin
      errors++;
      $display("FAIL empty_shadow: got %h want a4", q_shadow);
    end
  endtask

  task automatic test_arbitration;
    int w, c, ac, want;
    for (int rnd = 0; rnd < 3; rnd++) begin
      @(posedge clk); #1;
      r0_req = 1'b1; r0_addr = 3'd2; r0_dat = 1'b1;
      r1_req = 1'b1; r1_byte = 8'h00; r1_mask = 8'h01;
      w = -1; ac = -1; c = -1;
      while (c < 12 && w < 0) begin
        @(negedge clk);
        c++;
        if (r0_ack) begin w = 0; ac = c; end
        else if (r1_ack) begin w = 1; ac = c; end
      end
      @(posedge clk); #1;
      r0_req = 1'b0; r1_req = 1'b0;
      @(negedge clk);
`ifdef MC14500_LATCH_CTRL_RR_EN
      want = (rnd == 1) ? 1 : 0;
`else
      want = 0;
`endif
      checks++;
      if (w !== want || ac !== 3) begin
        errors++;
        $display("FAIL arb_round%0d: winner=%0d ack_cycle=%0d want %0d 3",
                 rnd, w, ac, want);
      end
    end
  endtask

  task automatic test_reset_midop;
    @(posedge clk); #1;
    r1_req = 1'b1; r1_byte = 8'hFF; r1_mask = 8'hFF;
    repeat (9) @(negedge clk);
    checks++;
    if (l_stb !== 1'b1 || l_a !== 3'd2) begin
      errors++;
      $display("FAIL midop_pre: stb=%b a=%0d want 1 2", l_stb, l_a);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (l_stb !== 1'b0 || busy !== 1'b0 || q_shadow !== 8'h00
        || r1_ack !== 1'b0 || l_a !== 3'd0) begin
      errors++;
      $display("FAIL midop_async: stb=%b busy=%b sh=%h ack=%b a=%0d want 0 0 00 0 0",
               l_stb, busy, q_shadow, r1_ack, l_a);
    end
    r1_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || r1_ack !== 1'b0 || l_stb !== 1'b0) begin
      errors++;
      $display("FAIL midop_idle: busy=%b ack=%b stb=%b want 0 0 0",
               busy, r1_ack, l_stb);
    end
  endtask

  task automatic test_after_reset;
    int ac, c;
    @(posedge clk); #1;
    r0_req = 1'b1; r0_addr = 3'd3; r0_dat = 1'b1;
    ac = -1; c = -1;
    while (c < 10 && ac < 0) begin
      @(negedge clk);
      c++;
      if (r0_ack) ac = c;
    end
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ac !== 3 || q_shadow !== 8'h08) begin
      errors++;
      $display("FAIL fresh_r0: ack_cycle=%0d sh=%h want 3 08", ac, q_shadow);
    end
  endtask

  initial begin
    test_reset();
    test_r0_write();
    test_byte_full();
    test_byte_sparse();
    test_byte_empty();
    test_arbitration();
    test_reset_midop();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc14500_latch_ctrl.md
# mc14500_latch_ctrl

Write sequencer and arbiter for the MC14500B companion 8-bit addressable output latch. It shares the latch between two requesters: the ICU core, which issues single-bit writes, and a host port, which issues masked byte loads. Every update is turned into setup/strobe/hold cycles on the latch's address, data and strobe pins, with the address held stable for the whole strobe. The block keeps a shadow copy of the latch contents for readback.

## Interface
Parameters:
- none; widths are fixed: 3-bit latch address, 8 latch bits.

Ports (reset asynchronous, active-low):
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous active-low reset; also wired to the latch reset, so latch and shadow clear together.
- `r0_req`  in  1  core bit-write request; held until `r0_ack`.
- `r0_addr`  in  3  latch bit address for r0; stable while `r0_req` is high.
- `r0_dat`  in  1  bit value for r0.
- `r0_ack`  out  1  one-cycle pulse: r0 write complete.
- `r1_req`  in  1  host byte-load request; held until `r1_ack`.
- `r1_byte`  in  8  byte value; stable while `r1_req` is high.
- `r1_mask`  in  8  bits to write; bit i set means latch bit i is updated.
- `r1_ack`  out  1  one-cycle pulse: byte load complete.
- `l_a`  out  3  latch address.
- `l_dat`  out  1  latch data.
- `l_stb`  out  1  latch strobe, active-high, level-sensitive.
- `q_shadow`  out  8  current latch contents as written by this block.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset: every output is 0 (`l_a`, `l_dat`, `l_stb`, both acks, `busy`, `q_shadow`). State is IDLE. Round-robin pointer selects r0 first.
- States: IDLE, SETUP, STROBE, HOLD, EMPTY.
- IDLE: sample the requests and grant one.
  - r0 granted: latch `r0_addr`/`r0_dat` into working registers, go to SETUP.
  - r1 granted with mask nonzero: capture byte and mask, index = lowest set mask bit, go to SETUP.
  - r1 granted with mask zero: go to EMPTY.
- SETUP: drive `l_a` and `l_dat`; `l_stb` = 0.
- STROBE: `l_stb` = 1, address and data unchanged. At the end of this cycle, `q_shadow[l_a]` ← `l_dat`.
- HOLD: `l_stb` = 0, address and data unchanged.
  - If the working mask still has a set bit above the current index, go to SETUP with the next set index. Unset bits are skipped in zero cycles.
  - Otherwise assert the requester's ack and go to IDLE.
- EMPTY: `r1_ack` = 1, then go to IDLE. No strobe is issued.
- Arbitration, default: fixed priority, r0 over r1.
- Requests are sampled only in IDLE. Changes to req or data while busy are ignored. A requester must drop req in the cycle after its ack.
- `l_a` and `l_dat` keep their last values in IDLE; they do not return to 0.

## Timing
- Grant cycle is IDLE (cycle 0). SETUP = cycle 1, STROBE = cycle 2, HOLD = cycle 3.
- r0 latency: ack in cycle 3. The next grant is possible in cycle 4.
- r1 latency with n set mask bits: 3n cycles after grant. Ack in the final HOLD.
- r1 with mask = 0: ack in cycle 1.
- `l_stb` is high for exactly one cycle per bit. Address and data are stable for one cycle before and one cycle after the strobe.
- Reset mid-operation: all outputs drop to 0 asynchronously, including `l_stb`. No ack is issued. The transfer in progress is abandoned, not resumed.

## Configuration
- `MC14500_LATCH_CTRL_RR_EN`
  - Defined: round-robin arbitration. When both requests are high in IDLE, the requester not granted last wins. The pointer resets to favour r0.
  - Undefined: fixed priority, r0 over r1. The pointer logic is not built.

## Structure
- Shared package `mc14500_pkg`: state encoding constants, `LATCH_AW` = 3, `LATCH_W` = 8.
- Sub-module `mc14500_lsb_find`: combinational lowest-set-bit finder. Takes the 8-bit mask restricted to bits above the current index; returns a 3-bit index and a valid flag. Used for both the first-bit and next-bit decisions.

## Test plan
- Reset, then r0 write with addr = 5, dat = 1 → `l_a` = 5 and `l_dat` = 1 from cycle 1; `l_stb` high only in cycle 2; `r0_ack` in cycle 3; `q_shadow` = 0x20.
- r1 with byte = 0xA5, mask = 0xFF → 8 strobes at `l_a` = 0..7 carrying `l_dat` = 1,0,1,0,0,1,0,1; one `r1_ack` at cycle 24; `q_shadow` = 0xA5.
- r1 with byte = 0x80, mask = 0x81 → strobes only at `l_a` = 0 (dat 0) and `l_a` = 7 (dat 1); `r1_ack` at cycle 6. Then r1 with mask = 0x00 → no strobe, `r1_ack` at cycle 1.
- r0 and r1 requesting continuously:
  - without the macro, r0 wins every arbitration;
  - with `MC14500_LATCH_CTRL_RR_EN`, grants alternate r0, r1, r0.
- `rst` asserted during the STROBE of the third bit of a 0xFF byte load → `l_stb`, `busy` and `q_shadow` go to 0 immediately; no `r1_ack`. After reset is released the block sits in IDLE and serves a fresh request normally.
